// File: rtl/music_pkg.sv
// Shared definitions for the sound blocks: sequencer state encoding, key-code helpers and
// the tone half-period table (C4..C5 at 50 MHz).
// No ports (package).
package music_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StLoad,
      StPlay,
      StGap,
      StEnds
   } state_e;

   // Wide enough for the lowest note (C4, 95556 cycles per half period).
   localparam int unsigned HALF_BITS = 17;
   localparam int unsigned REST_KEY  = 0;

   // End-of-score marker: all ones at the given key width, zero-extended to 16 bits.
   function automatic logic [15:0] end_key(input int unsigned key_bits);
      return 16'((32'd1 << key_bits) - 32'd1);
   endfunction

   // Half period in clock cycles for keys 1..8. The fast table (2*key+1) lets short
   // simulations see several toggles per note.
   function automatic logic [HALF_BITS-1:0] tone_half(input logic [7:0] key, input bit fast);
      if (fast) begin
         return HALF_BITS'({key, 1'b1});
      end
      case (key)
         8'd1:    return 17'd95556;  // C4
         8'd2:    return 17'd85131;  // D4
         8'd3:    return 17'd75843;  // E4
         8'd4:    return 17'd71586;  // F4
         8'd5:    return 17'd63776;  // G4
         8'd6:    return 17'd56818;  // A4
         8'd7:    return 17'd50619;  // B4
         8'd8:    return 17'd47778;  // C5
         default: return 17'd1;
      endcase
   endfunction

endpackage

// File: rtl/score_player_seq_if.sv
// Bundle between the score player and its surroundings (buttons, score RAM, speaker pin).
//  play/stop/loop/start_addr : control from the button logic
//  mem_addr / mem_key/mem_time : synchronous score RAM read port (1-cycle latency)
//  speaker/busy/note_active/done : status and audio out
// master = controller + RAM side, slave = score_player_seq.
interface score_player_seq_if #(
   parameter int unsigned ADDR_BITS = 5,
   parameter int unsigned KEY_BITS  = 4,
   parameter int unsigned TIME_BITS = 4
);
   logic                 play;
   logic                 stop;
   logic                 loop;
   logic [ADDR_BITS-1:0] start_addr;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [KEY_BITS-1:0]  mem_key;
   logic [TIME_BITS-1:0] mem_time;
   logic                 speaker;
   logic                 busy;
   logic                 note_active;
   logic                 done;

   modport master (
      output play, stop, loop, start_addr, mem_key, mem_time,
      input  mem_addr, speaker, busy, note_active, done
   );

   modport slave (
      input  play, stop, loop, start_addr, mem_key, mem_time,
      output mem_addr, speaker, busy, note_active, done
   );
endinterface

// File: rtl/tone_gen.sv
// Square-wave tone generator: toggles the speaker flop every tone_half(key) enabled cycles.
//  i_clk, i_rst : clock, async active-high reset
//  i_en         : tone runs (note sounding); output forced low when clear
//  i_clr        : synchronous phase clear, so every note starts low
//  i_key        : key code selecting the half period
//  o_speaker    : square-wave output
module tone_gen import music_pkg::*; #(
   parameter int unsigned KEY_BITS   = 4,
   parameter bit          FAST_TONES = 1'b0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_en,
   input  logic                i_clr,
   input  logic [KEY_BITS-1:0] i_key,
   output logic                o_speaker
);

   logic [HALF_BITS-1:0] w_half;
   logic [HALF_BITS-1:0] r_ph;
   logic                 r_spk;

   assign w_half = tone_half(8'(i_key), FAST_TONES);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ph  <= '0;
         r_spk <= 1'b0;
      end else if (i_clr) begin
         r_ph  <= '0;
         r_spk <= 1'b0;
      end else if (i_en) begin
         if (r_ph >= w_half - HALF_BITS'(1)) begin
            r_ph  <= '0;
            r_spk <= ~r_spk;
         end else begin
            r_ph <= r_ph + HALF_BITS'(1);
         end
      end
   end

   // Gate with enable so the pin drops in the very cycle the note ends, is cut or reset.
   assign o_speaker = r_spk & i_en;

endmodule

// File: rtl/score_player_seq.sv
// Score player: fetches (key, time) notes from an external synchronous score RAM and plays
// them as square-wave tones with tempo scaling, rests, articulation gaps, loop, retrigger
// and stop.
//  i_clk, i_rst : clock, async active-high reset
//  io_bus       : play/stop/loop/start_addr in, score RAM port, speaker/busy/note_active/done
module score_player_seq import music_pkg::*; #(
   parameter int unsigned ADDR_BITS  = 5,
   parameter int unsigned KEY_BITS   = 4,
   parameter int unsigned TIME_BITS  = 4,
   parameter int unsigned NUM_KEYS   = 8,
   parameter int unsigned TICK_DIV   = 12_500_000,
   parameter int unsigned GAP_CYC    = 500_000,   // must be >= 1
   parameter bit          FAST_TONES = 1'b0
) (
   input logic                i_clk,
   input logic                i_rst,
   score_player_seq_if.slave  io_bus
);

   localparam int unsigned DUR_BITS = TIME_BITS + $clog2(TICK_DIV) + 1;
   localparam int unsigned GAP_BITS = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   state_e               r_state;
   logic [ADDR_BITS-1:0] r_addr;
   logic [ADDR_BITS-1:0] r_start;
   logic [KEY_BITS-1:0]  r_key;
   logic [DUR_BITS-1:0]  r_dur;
   logic [GAP_BITS-1:0]  r_gap;
   logic                 r_busy;
   logic                 r_note;
   logic                 r_done;

   logic                 w_key_end;
   logic                 w_key_tone;
   logic [DUR_BITS-1:0]  w_dur_load;
   logic                 w_tone_en;
   logic                 w_tone_clr;
   logic                 w_spk;

   assign w_key_end  = (16'(io_bus.mem_key) == end_key(KEY_BITS));
   // Out-of-table codes play as rests.
   assign w_key_tone = (io_bus.mem_key != KEY_BITS'(REST_KEY)) &&
                       (32'(io_bus.mem_key) <= NUM_KEYS);
   assign w_dur_load = DUR_BITS'(io_bus.mem_time) * DUR_BITS'(TICK_DIV) - DUR_BITS'(1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_addr  <= '0;
         r_start <= '0;
         r_key   <= '0;
         r_dur   <= '0;
         r_gap   <= '0;
         r_busy  <= 1'b0;
         r_note  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (io_bus.stop && (r_state != StIdle)) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_note  <= 1'b0;
         end else if (io_bus.play && !io_bus.stop) begin
            // Start from idle or retrigger: any note in progress is cut.
            r_start <= io_bus.start_addr;
            r_addr  <= io_bus.start_addr;
            r_busy  <= 1'b1;
            r_note  <= 1'b0;
            r_state <= StFetch;
         end else begin
            unique case (r_state)
               StIdle: ;
               StFetch: r_state <= StWait;
               StWait:  r_state <= StLoad;
               StLoad: begin
                  r_key <= io_bus.mem_key;
                  if (w_key_end) begin
                     r_done  <= 1'b1;
                     r_state <= StEnds;
                  end else if (io_bus.mem_time == '0) begin
                     r_addr  <= r_addr + ADDR_BITS'(1);
                     r_state <= StFetch;
                  end else begin
                     r_dur   <= w_dur_load;
                     r_note  <= w_key_tone;
                     r_state <= StPlay;
                  end
               end
               StPlay: begin
                  if (r_dur == '0) begin
                     r_note  <= 1'b0;
                     r_gap   <= GAP_BITS'(GAP_CYC - 1);
                     r_state <= StGap;
                  end else begin
                     r_dur <= r_dur - DUR_BITS'(1);
                  end
               end
               StGap: begin
                  if (r_gap == '0) begin
                     r_addr  <= r_addr + ADDR_BITS'(1);
                     r_state <= StFetch;
                  end else begin
                     r_gap <= r_gap - GAP_BITS'(1);
                  end
               end
               StEnds: begin
                  if (io_bus.loop) begin
                     r_addr  <= r_start;
                     r_state <= StFetch;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= StIdle;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign w_tone_en  = (r_state == StPlay) && r_note;
   assign w_tone_clr = (r_state == StLoad);

   tone_gen #(
      .KEY_BITS   (KEY_BITS),
      .FAST_TONES (FAST_TONES)
   ) u_tone (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (w_tone_en),
      .i_clr     (w_tone_clr),
      .i_key     (r_key),
      .o_speaker (w_spk)
   );

   assign io_bus.mem_addr    = r_addr;
   assign io_bus.speaker     = w_spk;
   assign io_bus.busy        = r_busy;
   assign io_bus.note_active = r_note;
   assign io_bus.done        = r_done;

endmodule

// File: tb/tb_score_player_seq.sv
// Directed bench for score_player_seq with TICK_DIV=4, GAP_CYC=2 and the fast tone table
// (tone_half(1)=3, tone_half(2)=5). Trace index k is the sample taken just after the k-th
// clock edge following the stimulus.
module tb_score_player_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [3:0]  ram_key  [32];
   logic [3:0]  ram_time [32];
   logic [63:0] tr_spk, tr_na, tr_done, tr_busy;
   logic [4:0]  tr_addr  [64];

   score_player_seq_if #(.ADDR_BITS(5), .KEY_BITS(4), .TIME_BITS(4)) bus ();

   score_player_seq #(
      .ADDR_BITS  (5),
      .KEY_BITS   (4),
      .TIME_BITS  (4),
      .NUM_KEYS   (8),
      .TICK_DIV   (4),
      .GAP_CYC    (2),
      .FAST_TONES (1'b1)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   // Synchronous score RAM, one cycle read latency.
   always_ff @(posedge clk) begin
      bus.mem_key  <= ram_key[bus.mem_addr];
      bus.mem_time <= ram_time[bus.mem_addr];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      bus.play = 1'b0;
      bus.stop = 1'b0;
   endtask

   task automatic trace(input int n);
      tr_spk  = '0;
      tr_na   = '0;
      tr_done = '0;
      tr_busy = '0;
      for (int i = 0; i < n; i++) begin
         cyc();
         tr_spk[i]  = bus.speaker;
         tr_na[i]   = bus.note_active;
         tr_done[i] = bus.done;
         tr_busy[i] = bus.busy;
         tr_addr[i] = bus.mem_addr;
      end
   endtask

   task automatic start(input logic [4:0] sa);
      bus.start_addr = sa;
      bus.play       = 1'b1;
   endtask

   initial begin
      bus.play       = 1'b0;
      bus.stop       = 1'b0;
      bus.loop       = 1'b0;
      bus.start_addr = '0;
      for (int i = 0; i < 32; i++) begin
         ram_key[i]  = 4'hF;
         ram_time[i] = 4'h0;
      end
      ram_key[0] = 4'd1; ram_time[0] = 4'd2;
      ram_key[1] = 4'd2; ram_time[1] = 4'd1;
      ram_key[2] = 4'hF;
      ram_key[5] = 4'd0; ram_time[5] = 4'd3;
      ram_key[6] = 4'd3; ram_time[6] = 4'd0;
      ram_key[7] = 4'hF;

      // Reset state
      #12;
      check("rst_spk",  bus.speaker, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_na",   bus.note_active, 0);
      check("rst_done", bus.done, 0);
      check("rst_addr", bus.mem_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc();
      cyc();

      // Two notes then end marker, no loop
      start(5'd0);
      trace(30);
      check("t2_spk_note1", tr_spk[10:3], 8'b0011_1000);
      check("t2_na_note1",  tr_na[11:2], 10'b01_1111_1110);
      check("t2_spk_rest",  tr_spk[29:11], 0);
      check("t2_na_note2",  tr_na[20:15], 6'b01_1110);
      check("t2_done",      tr_done, 64'd1 << 25);
      check("t2_busy",      tr_busy, 64'h3FF_FFFF);
      check("t2_addr0",     tr_addr[0], 0);
      check("t2_addr1",     tr_addr[13], 1);
      check("t2_addr2",     tr_addr[22], 2);

      // Asynchronous reset in the middle of a sounding note
      start(5'd0);
      trace(7);
      check("t1_pre_spk", bus.speaker, 1);
      check("t1_pre_na",  bus.note_active, 1);
      #3;
      rst = 1'b1;
      #1;
      check("t1_spk",  bus.speaker, 0);
      check("t1_busy", bus.busy, 0);
      check("t1_na",   bus.note_active, 0);
      check("t1_done", bus.done, 0);
      check("t1_addr", bus.mem_addr, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      trace(10);
      check("t1_no_resume", tr_busy | tr_na | tr_spk, 0);

      // Loop mode: a Done per pass, Busy held
      bus.loop = 1'b1;
      start(5'd0);
      trace(60);
      check("t3_done",  tr_done, (64'd1 << 25) | (64'd1 << 51));
      check("t3_busy",  tr_busy, 64'h0FFF_FFFF_FFFF_FFFF);
      check("t3_wrap",  tr_addr[26], 0);
      check("t3_addr1", tr_addr[39], 1);
      bus.loop = 1'b0;
      bus.stop = 1'b1;
      cyc();
      check("t3_stop_busy", bus.busy, 0);

      // Rest note, zero-time skip, end at address 7
      start(5'd5);
      trace(30);
      check("t4_spk",   tr_spk, 0);
      check("t4_na",    tr_na, 0);
      check("t4_done",  tr_done, 64'd1 << 23);
      check("t4_busy",  tr_busy, 64'hFF_FFFF);
      check("t4_addr6", tr_addr[17], 6);
      check("t4_addr7", tr_addr[20], 7);

      // Stop during second note; Play+Stop together from idle
      start(5'd0);
      trace(17);
      check("t5_pre_na", tr_na[16], 1);
      bus.stop = 1'b1;
      cyc();
      check("t5_busy", bus.busy, 0);
      check("t5_na",   bus.note_active, 0);
      check("t5_spk",  bus.speaker, 0);
      trace(30);
      check("t5_no_done", tr_done, 0);
      check("t5_idle",    tr_busy, 0);
      bus.play = 1'b1;
      bus.stop = 1'b1;
      trace(5);
      check("t5_playstop", tr_busy, 0);

      // Retrigger during first note, then again during second note to another score
      start(5'd0);
      trace(7);
      check("t6_pre_spk", tr_spk[6], 1);
      start(5'd0);
      cyc();
      check("t6_spk",  bus.speaker, 0);
      check("t6_na",   bus.note_active, 0);
      check("t6_addr", bus.mem_addr, 0);
      trace(16);
      check("t6_replay_spk", tr_spk[9:2], 8'b0011_1000);
      check("t6_replay_na",  tr_na[15], 1);
      check("t6_replay_a1",  tr_addr[15], 1);
      start(5'd5);
      cyc();
      check("t6_relatch", bus.mem_addr, 5);
      check("t6_cut_na",  bus.note_active, 0);
      trace(30);
      check("t6_done", tr_done, 64'd1 << 22);
      check("t6_busy", tr_busy, 64'h7F_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
